ram_sweep_ctrl: RTL and testbench



---
 rtl/ram_sweep_ctrl_if.sv | 29 ++
 rtl/ram_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_ram_sweep_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ram_sweep_ctrl_if.sv
// RAM-side port bundle of the sweep controller: one write port and one
// registered read port of a 1R/1W synchronous RAM.
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

interface ram_sweep_ctrl_if #(
    parameter int BRAM_ADDR_WIDTH = `ADDR_LEN,
    parameter int BRAM_DATA_WIDTH = `DATA_LEN
);
    logic [BRAM_ADDR_WIDTH-1:0] waddr;
    logic [BRAM_DATA_WIDTH-1:0] wdata;
    logic                       we;
    logic [BRAM_ADDR_WIDTH-1:0] raddr;
    logic [BRAM_DATA_WIDTH-1:0] rdata;

    modport master (
        output waddr, wdata, we, raddr,
        input  rdata
    );

    modport slave (
        input  waddr, wdata, we, raddr,
        output rdata
    );
endinterface

// File: rtl/ram_sweep_ctrl.sv
// Fills every RAM entry with a latched value, then optionally reads the
// array back and records the address of the first entry that disagrees.
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module ram_sweep_ctrl #(
    parameter int BRAM_ADDR_WIDTH = `ADDR_LEN,
    parameter int BRAM_DATA_WIDTH = `DATA_LEN,
    parameter int DATA_DEPTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BRAM_DATA_WIDTH-1:0] fill,
    input  logic                       verify_en,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [BRAM_ADDR_WIDTH-1:0] err_addr,
    ram_sweep_ctrl_if.master           ram
);
    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST = BRAM_ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ONE  = BRAM_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [BRAM_DATA_WIDTH-1:0] fill_q;
    logic                       ver_q;
    logic                       cmp_v_q;
    logic [BRAM_ADDR_WIDTH-1:0] cmp_addr_q;
    logic                       error_q;
    logic [BRAM_ADDR_WIDTH-1:0] err_addr_q;
    logic                       start_acc;
    logic                       mismatch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WRITE;
                    cnt_d     = '0;
                    start_acc = 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
                    state_d = ver_q ? READ : DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            READ: begin
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DRAIN: begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM port and status outputs decode straight from state and counter.
    always_comb begin
        ram.we    = 1'b0;
        ram.waddr = '0;
        ram.wdata = '0;
        ram.raddr = '0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        if (state_q == WRITE) begin
            ram.we    = 1'b1;
            ram.waddr = cnt_q;
            ram.wdata = fill_q;
        end
        if (state_q == READ) begin
            ram.raddr = cnt_q;
        end
    end

    // rdata belongs to the address issued one cycle earlier, held in cmp_addr_q.
    assign mismatch = cmp_v_q && (ram.rdata != fill_q) && !error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ver_q      <= 1'b0;
            cmp_v_q    <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmp_v_q <= (state_q == READ);
            if (start_acc) begin
                ver_q      <= verify_en;
                error_q    <= 1'b0;
                err_addr_q <= '0;
            end else if (mismatch) begin
                error_q    <= 1'b1;
                err_addr_q <= cmp_addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        cmp_addr_q <= cnt_q;
        if (start_acc) begin
            fill_q <= fill;
        end
    end

    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Bench for ram_sweep_ctrl: a D=32 instance driven with directed and random
// sweeps against a cycle-offset reference, plus a D=1 instance.
module tb_ram_sweep_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int D  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- D=32 instance ----------------
    logic          reset, start, verify_en;
    logic [DW-1:0] fill;
    logic          busy, done, error;
    logic [AW-1:0] err_addr;

    ram_sweep_ctrl_if #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) r32 ();

    ram_sweep_ctrl #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .fill(fill), .verify_en(verify_en),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr), .ram(r32)
    );

    logic [DW-1:0] mem [D];
    bit            corrupt [D];

    always @(posedge clk) begin
        if (r32.we) mem[r32.waddr] <= r32.wdata;
        r32.rdata <= corrupt[r32.raddr] ? ~mem[r32.raddr] : mem[r32.raddr];
    end

    // ---------------- D=1 instance ----------------
    logic          start1, verify1;
    logic [DW-1:0] fill1;
    logic          busy1, done1, error1;
    logic [0:0]    err_addr1;
    logic [DW-1:0] mem1;
    bit            corrupt1;

    ram_sweep_ctrl_if #(.BRAM_ADDR_WIDTH(1), .BRAM_DATA_WIDTH(DW)) r1 ();

    ram_sweep_ctrl #(.BRAM_ADDR_WIDTH(1), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .fill(fill1), .verify_en(verify1),
        .busy(busy1), .done(done1), .error(error1), .err_addr(err_addr1), .ram(r1)
    );

    always @(posedge clk) begin
        if (r1.we) mem1 <= r1.wdata;
        r1.rdata <= corrupt1 ? ~mem1 : mem1;
    end

    // Full sweep on the D=32 instance; n counts cycles after the accepting edge.
    task automatic run_sweep(input logic [DW-1:0] f, input bit ver, input bit spam,
                             input int ca, input int cb);
        int ek, dc;
        bit exp_we, exp_err;
        logic [AW-1:0] exp_wa, exp_ra;
        for (int i = 0; i < D; i++) corrupt[i] = 1'b0;
        if (ca >= 0) corrupt[ca] = 1'b1;
        if (cb >= 0) corrupt[cb] = 1'b1;
        ek = -1;
        if (ver) begin
            for (int i = D - 1; i >= 0; i--) if (corrupt[i]) ek = i;
        end
        dc = ver ? 2 * D + 2 : D + 1;
        @(negedge clk);
        fill = f; verify_en = ver; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= dc + 1; n++) begin
            @(negedge clk);
            exp_we  = (n >= 1 && n <= D);
            exp_wa  = exp_we ? AW'(n - 1) : '0;
            exp_ra  = (ver && n >= D + 1 && n <= 2 * D) ? AW'(n - D - 1) : '0;
            exp_err = (ek >= 0) && (n >= D + ek + 3);
            check($sformatf("busy@%0d", n),  busy,  (n <= dc));
            check($sformatf("done@%0d", n),  done,  (n == dc));
            check($sformatf("we@%0d", n),    r32.we, exp_we);
            check($sformatf("waddr@%0d", n), r32.waddr, exp_wa);
            check($sformatf("wdata@%0d", n), r32.wdata, exp_we ? f : '0);
            check($sformatf("raddr@%0d", n), r32.raddr, exp_ra);
            check($sformatf("error@%0d", n), error, exp_err);
            check($sformatf("err_addr@%0d", n), err_addr, exp_err ? AW'(ek) : '0);
            if (spam && n <= dc) begin
                start     = (n == dc) ? 1'b1 : 1'($urandom_range(0, 1));
                fill      = $urandom;
                verify_en = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
                fill  = $urandom;
            end
        end
        start = 1'b0;
        for (int i = 0; i < D; i++) check($sformatf("mem[%0d]", i), mem[i], f);
        for (int i = 0; i < D; i++) corrupt[i] = 1'b0;
    endtask

    task automatic run_d1(input logic [DW-1:0] f, input bit cor);
        corrupt1 = cor;
        @(negedge clk);
        fill1 = f; verify1 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("d1_busy@%0d", n), busy1, (n <= 4));
            check($sformatf("d1_done@%0d", n), done1, (n == 4));
            check($sformatf("d1_we@%0d", n), r1.we, (n == 1));
            check($sformatf("d1_error@%0d", n), error1, cor && (n >= 4));
        end
        check("d1_err_addr", err_addr1, 1'b0);
        check("d1_mem", mem1, f);
        corrupt1 = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] prev_fill;
        reset = 1'b1; start = 1'b0; fill = '0; verify_en = 1'b0;
        start1 = 1'b0; fill1 = '0; verify1 = 1'b0; corrupt1 = 1'b0; mem1 = '0;
        for (int i = 0; i < D; i++) begin mem[i] = '0; corrupt[i] = 1'b0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_err_addr", err_addr, '0);
        check("rst_we", r32.we, 1'b0);
        check("rst_waddr", r32.waddr, '0);
        check("rst_wdata", r32.wdata, '0);
        check("rst_raddr", r32.raddr, '0);
        check("rst_busy1", busy1, 1'b0);
        reset = 1'b0;

        // start held high together with reset must not launch a sweep
        start = 1'b1; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_wins_busy", busy, 1'b0);
        start = 1'b0; reset = 1'b0;

        run_sweep(32'hDEADBEEF, 1'b0, 1'b0, -1, -1);
        run_sweep(32'hDEADBEEF, 1'b1, 1'b0, -1, -1);
        run_sweep(32'h0F0F1234, 1'b1, 1'b0, 9, 5);
        run_sweep(32'h0BADF00D, 1'b1, 1'b1, -1, -1);
        run_sweep(32'h13579BDF, 1'b1, 1'b0, 31, -1);
        run_sweep(32'hCAFEF00D, 1'b0, 1'b1, 3, -1);

        // reset in the middle of WRITE (cnt=10)
        prev_fill = mem[20];
        @(negedge clk);
        fill = 32'hA5A5A5A5; verify_en = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_waddr", r32.waddr, AW'(10));
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("mid_we", r32.we, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_error", error, 1'b0);
        check("mid_waddr0", r32.waddr, '0);
        check("mid_mem9", mem[9], 32'hA5A5A5A5);
        check("mid_mem20", mem[20], prev_fill);
        run_sweep(32'h5A5A0001, 1'b1, 1'b0, 0, -1);

        for (int it = 0; it < 8; it++) begin
            int ca, cb;
            ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, D - 1)) : -1;
            cb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, D - 1)) : -1;
            run_sweep($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ca, cb);
        end

        run_d1(32'h00C0FFEE, 1'b0);
        run_d1(32'h12345678, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
